// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared binary32 constants, divider FSM state type and packing helper
package fp32_pkg;

   localparam int          EXP_BIAS  = 127;
   localparam logic [22:0] QNAN_FRAC = 23'h400000;
   localparam logic [7:0]  EXP_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      ROUND,
      DONE
   } state_t;

   function automatic logic [31:0] pack_fp(input logic s, input logic [7:0] e, input logic [22:0] f);
      return {s, e, f};
   endfunction

endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - binary32 operand classifier (zero with DAZ, infinity, NaN)
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [30:0] mag_i,
   output logic        is_zero_o,
   output logic        is_inf_o,
   output logic        is_nan_o
);

   logic [7:0]  exp_f;
   logic [22:0] frac_f;

   assign exp_f  = mag_i[30:23];
   assign frac_f = mag_i[22:0];

   // Denormals have exp==0 and are treated as zero.
   assign is_zero_o = (exp_f == 8'h00);
   assign is_inf_o  = (exp_f == EXP_MAX) && (frac_f == 23'd0);
   assign is_nan_o  = (exp_f == EXP_MAX) && (frac_f != 23'd0);

endmodule

// File: rtl/fp32_div_iter.sv
// rtl/fp32_div_iter.sv - iterative binary32 divider, one restoring step per cycle, RNE, FTZ/DAZ
module fp32_div_iter
   import fp32_pkg::*;
#(
   parameter int QBITS = 25
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Q,
   output logic        div_by_zero
);

   state_t              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [24:0]         rem_q, rem_d;
   logic [23:0]         div_q, div_d;
   logic [QBITS-1:0]    quo_q, quo_d;
   logic signed [9:0]   exp_q, exp_d;
   logic                sign_q, sign_d;
   logic [31:0]         q_q, q_d;
   logic                dbz_q, dbz_d;

   logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic sign_in;
   logic [23:0] ma, mb;
   logic        m_lt;

   fp32_classify u_cls_a (.mag_i(A[30:0]), .is_zero_o(a_zero), .is_inf_o(a_inf), .is_nan_o(a_nan));
   fp32_classify u_cls_b (.mag_i(B[30:0]), .is_zero_o(b_zero), .is_inf_o(b_inf), .is_nan_o(b_nan));

   assign sign_in = A[31] ^ B[31];
   assign ma      = {1'b1, A[22:0]};
   assign mb      = {1'b1, B[22:0]};
   assign m_lt    = (ma < mb);

   logic        step_take;
   logic [24:0] step_rem;

   assign step_take = (rem_q >= {1'b0, div_q});
   assign step_rem  = step_take ? (rem_q - {1'b0, div_q}) : rem_q;

   // Top 24 quotient bits are the significand, the next one is the guard.
   logic [23:0]       sig;
   logic              guard, sticky, round_up;
   logic [24:0]       sum;
   logic signed [9:0] exp_rnd;
   logic [22:0]       frac_rnd;

   assign sig      = quo_q[QBITS-1 -: 24];
   assign guard    = quo_q[QBITS-25];
   assign sticky   = (rem_q != 25'd0);
   assign round_up = guard & (sticky | sig[0]);
   assign sum      = {1'b0, sig} + {24'd0, round_up};
   assign exp_rnd  = exp_q + {9'd0, sum[24]};
   assign frac_rnd = sum[24] ? sum[23:1] : sum[22:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         rem_q   <= 25'd0;
         div_q   <= 24'd0;
         quo_q   <= '0;
         exp_q   <= 10'sd0;
         sign_q  <= 1'b0;
         q_q     <= 32'd0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         q_q     <= q_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      div_d   = div_q;
      quo_d   = quo_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      q_d     = q_q;
      dbz_d   = dbz_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d = sign_in;
               dbz_d  = 1'b0;
               if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                  q_d     = pack_fp(sign_in, EXP_MAX, QNAN_FRAC);
                  state_d = DONE;
               end else if (a_inf || b_zero) begin
                  q_d     = pack_fp(sign_in, EXP_MAX, 23'd0);
                  dbz_d   = b_zero && !a_inf;
                  state_d = DONE;
               end else if (a_zero || b_inf) begin
                  q_d     = pack_fp(sign_in, 8'h00, 23'd0);
                  state_d = DONE;
               end else begin
                  // Pre-scale so the first quotient bit is always 1.
                  rem_d   = m_lt ? {ma, 1'b0} : {1'b0, ma};
                  div_d   = mb;
                  quo_d   = '0;
                  exp_d   = {2'b00, A[30:23]} - {2'b00, B[30:23]} + 10'(EXP_BIAS) - {9'd0, m_lt};
                  cnt_d   = 5'd0;
                  state_d = DIVIDE;
               end
            end
         end
         DIVIDE: begin
            quo_d = {quo_q[QBITS-2:0], step_take};
            rem_d = step_rem << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(QBITS - 1)) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (exp_rnd >= 10'sd255) begin
               q_d = pack_fp(sign_q, EXP_MAX, 23'd0);
            end else if (exp_rnd <= 10'sd0) begin
               q_d = pack_fp(sign_q, 8'h00, 23'd0);
            end else begin
               q_d = pack_fp(sign_q, exp_rnd[7:0], frac_rnd);
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign Q           = q_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp32_div_iter.sv
// tb/tb_fp32_div_iter.sv - self-checking bench for fp32_div_iter with integer-division reference model
module tb_fp32_div_iter;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Q;
   logic        div_by_zero;

   int vec_cnt = 0;
   int mis_cnt = 0;

   fp32_div_iter #(.QBITS(25)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .Q(Q), .div_by_zero(div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vec_cnt++;
      assert (obs === expv) else begin
         mis_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: exact integer quotient with spare bits, then generic round-to-nearest-even.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic dbz, output logic special);
      logic s, az, bz, ai, bi, an, bn;
      int ea, eb, e, sh;
      longint unsigned ma, mb, num, quo, rmd, sig, rest, half;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      az = (ea == 0);
      bz = (eb == 0);
      ai = (ea == 255) && (a[22:0] == 0);
      bi = (eb == 255) && (b[22:0] == 0);
      an = (ea == 255) && (a[22:0] != 0);
      bn = (eb == 255) && (b[22:0] != 0);
      dbz = 1'b0;
      special = 1'b1;
      if (an || bn || (az && bz) || (ai && bi)) q = {s, 8'hFF, 23'h400000};
      else if (ai) q = {s, 8'hFF, 23'h0};
      else if (bz) begin q = {s, 8'hFF, 23'h0}; dbz = 1'b1; end
      else if (az || bi) q = {s, 31'h0};
      else begin
         special = 1'b0;
         ma  = 64'h800000 | 64'(a[22:0]);
         mb  = 64'h800000 | 64'(b[22:0]);
         num = ma << 30;
         quo = num / mb;
         rmd = num % mb;
         e   = ea - eb + 127;
         if (quo >= (64'd1 << 30)) sh = 7;
         else begin sh = 6; e = e - 1; end
         sig  = quo >> sh;
         rest = quo & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         if (rest > half || (rest == half && (rmd != 0 || sig[0]))) sig = sig + 1;
         if (sig == (64'd1 << 24)) begin sig = sig >> 1; e = e + 1; end
         if (e >= 255) q = {s, 8'hFF, 23'h0};
         else if (e <= 0) q = {s, 31'h0};
         else q = {s, e[7:0], sig[22:0]};
      end
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] v;
      int mode;
      v = $urandom;
      mode = $urandom_range(0, 9);
      if (mode < 6) v[30:23] = 8'($urandom_range(154, 100));
      else if (mode >= 8) begin
         v[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
         if ($urandom_range(0, 1) != 0) v[22:0] = 23'd0;
      end
      return v;
   endfunction

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      A = a;
      B = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_op();
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      A = $urandom;
      B = $urandom;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("release_out_valid", {31'd0, out_valid}, 32'd0);
      check("no_accept_on_release", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic ed, input int el);
      int lat;
      start_op(a, b);
      wait_done(lat);
      check({tag, "_lat"}, 32'(lat), 32'(el));
      check({tag, "_q"}, Q, eq);
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ed});
      release_op();
   endtask

   initial begin
      logic [31:0] a, b, eq, q0;
      logic ed, sp;
      int lat, n;

      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      A = 32'd0;
      B = 32'd0;
      #1 rst = 1'b1;
      #3;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_q", Q, 32'd0);
      check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      directed("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27);
      directed("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 27);
      directed("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1);
      directed("zero_by_negzero", 32'h00000000, 32'h80000000, 32'hFFC00000, 1'b0, 1);
      directed("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 27);
      directed("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 27);
      directed("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1);
      directed("inf_by_zero", 32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 1);
      directed("finite_by_inf", 32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 1);

      start_op(32'h40490FDB, 32'h402DF854);
      wait_done(lat);
      model(32'h40490FDB, 32'h402DF854, eq, ed, sp);
      check("stall_lat", 32'(lat), 32'd27);
      check("stall_q", Q, eq);
      q0 = Q;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         A = $urandom;
         B = $urandom;
         @(posedge clk);
         #1;
         check($sformatf("stall_hold_q_%0d", i), Q, q0);
         check($sformatf("stall_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
         check($sformatf("stall_out_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      release_op();
      n = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (out_valid) n++;
      end
      check("stall_single_transfer", 32'(n), 32'd0);

      start_op(32'h40C00000, 32'h40000000);
      repeat (11) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) n++;
      end
      check("midrst_no_output", 32'(n), 32'd0);
      directed("after_rst", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 27);

      for (int i = 0; i < 60; i++) begin
         a = rnd_fp();
         b = rnd_fp();
         model(a, b, eq, ed, sp);
         start_op(a, b);
         wait_done(lat);
         check($sformatf("rnd%0d_lat a=%h b=%h", i, a, b), 32'(lat), sp ? 32'd1 : 32'd27);
         check($sformatf("rnd%0d_q a=%h b=%h", i, a, b), Q, eq);
         check($sformatf("rnd%0d_dbz a=%h b=%h", i, a, b), {31'd0, div_by_zero}, {31'd0, ed});
         release_op();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule

// File: doc/fp32_div_iter.md
FP32_DIV_ITER -- requirements
Module: fp32_div_iter

Interface
REQ-001 SHALL have parameter QBITS, default 25, number of quotient bits generated: 24 significand bits plus 1 guard bit.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair A/B is valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have port A, input, 32, IEEE-754 binary32 dividend.
REQ-007 SHALL have port B, input, 32, IEEE-754 binary32 divisor.
REQ-008 SHALL have port out_valid, output, 1, Q is valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts Q.
REQ-010 SHALL have port Q, output, 32, quotient A/B, binary32.
REQ-011 SHALL have port div_by_zero, output, 1, finite nonzero A divided by zero; valid with out_valid.

Function
REQ-012 SHALL use FSM states IDLE, DIVIDE, ROUND, DONE.
REQ-013 SHALL assert in_ready only in IDLE; a transfer occurs on an edge with in_valid && in_ready.
REQ-014 SHALL capture A and B on the accepting edge; later changes to A/B SHALL have no effect.
REQ-015 SHALL classify operands at accept: exp==0 means zero (denormals flushed, DAZ); exp==FF with frac==0 means inf; exp==FF with frac!=0 means NaN.
REQ-016 SHALL move IDLE->DONE on accept when a special case applies, so out_valid is high 1 cycle after accept.
REQ-017 SHALL apply special-case results with sign = sA^sB: NaN in, 0/0 or inf/inf gives {sign,FF,400000}; inf/finite or nonzero/0 gives {sign,FF,0}; 0/nonzero or finite/inf gives {sign,00,0}.
REQ-018 SHALL set div_by_zero=1 only for a finite nonzero A with a zero B, and 0 for every other case.
REQ-019 SHALL otherwise form mA={1,fracA} and mB={1,fracB} with 10-bit signed exponent e=eA-eB+127; if mA<mB, SHALL use 2*mA and decrement e.
REQ-020 SHALL in DIVIDE perform one restoring-division step per cycle, exactly QBITS cycles, counted by a 5-bit counter, then go to ROUND.
REQ-021 SHALL in ROUND form sticky = (remainder != 0) and round the 24-bit quotient RNE using guard, sticky and lsb.
REQ-022 SHALL in ROUND handle rounding carry-out (significand reaching 2.0) by setting frac to 0 and incrementing e.
REQ-023 SHALL give {sign,FF,0} if final e>=255 (overflow) and {sign,00,0} if final e<=0 (underflow, flush to zero).
REQ-024 SHALL produce out_valid 1 at QBITS+2 cycles after accept (27 at default) and move ROUND->DONE.
REQ-025 SHALL in DONE hold Q, div_by_zero and out_valid stable until out_ready is high on an edge, then return to IDLE.
REQ-026 SHALL accept no new operand while in DIVIDE, ROUND or DONE, so at most one operation is in flight.
REQ-027 SHALL not accept a new operand on the same edge DONE releases; the next accept is possible one cycle later.

Reset
REQ-028 SHALL on rst, asynchronously: FSM=IDLE, in_ready=1, out_valid=0, Q=0, div_by_zero=0, counter=0.
REQ-029 SHALL make rst asserted during DIVIDE/ROUND/DONE discard the operation with no out_valid pulse afterwards.

Structure
REQ-030 SHALL place constants in shared package fp32_pkg: EXP_BIAS=127, QNAN_FRAC=23'h400000, EXP_MAX=8'hFF, and an FSM state enum typedef.
REQ-031 SHALL use one combinational sub-module fp32_classify (zero/inf/nan flags per operand), reusable by other FP32 units.
REQ-032 SHALL contain no division or multiplication operator; the datapath uses subtract, compare and shift only.

Verification
REQ-033 SHALL cover: A=40C00000 (6.0), B=40000000 (2.0) -> Q=40400000, out_valid 27 cycles after accept.
REQ-034 SHALL cover: A=3F800000, B=40400000 -> Q=3EAAAAAB (RNE round-up checked).
REQ-035 SHALL cover: A=3F800000, B=00000000 -> Q=7F800000, div_by_zero=1, latency 1; A=00000000, B=80000000 -> Q=FFC00000, div_by_zero=0.
REQ-036 SHALL cover: A=7F000000, B=3E800000 -> Q=7F800000 (overflow); A=00800000, B=7F000000 -> Q=00000000 (underflow).
REQ-037 SHALL cover: out_ready held 0 for 10 cycles after out_valid -> Q stable, in_ready=0 throughout, one transfer on release.
REQ-038 SHALL cover: rst pulsed at cycle 12 of DIVIDE -> in_ready=1 and out_valid=0 immediately, and the next operation is correct.
